cnn_load_receiver: RTL

Receive side of the feature-map/weight load interface. Accepts write beats (data, address, active-low `done` window) from the load transmitter and stores them in local feature-map and per-kernel weight buffers. Tracks each load window and raises a ready flag and a one-cycle `conv_start` pulse once both buffers are loaded. Sits between the load transmitter and the convolution array, which reads the buffers through dedicated read ports.

---
 rtl/cnn_load_receiver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cnn_load_receiver.sv
// cnn_load_receiver: FM/weight load receiver with per-channel window FSMs and sync read ports (LOAD_CHECK_EN adds beat-count checking).
module cnn_load_chan #(
  parameter int AW = 6,
  parameter int EXP = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic          load_clear,
  input  logic          oor,
  input  logic [AW-1:0] addr,
  output logic          wr,
  output logic          is_done,
  output logic          err
);
`ifdef LOAD_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  state_t st;
  logic done_q, last_v, fall, newb, close, bad;
  logic [5:0] cnt, cnt_e;
  logic [AW-1:0] last_addr;
  always_comb begin
    fall = done_q & ~done;
    wr = ~done & (fall | (st == RECV));
    cnt_e = fall ? '0 : cnt;
    newb = wr & (fall | ~last_v | (addr != last_addr));
    close = (st == RECV) & done;
    bad = CHECK & (err | (cnt != 6'(EXP)));
  end
  // a falling edge restarts the window from any state, beating a same-cycle load_clear
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      done_q <= 1'b1;
      cnt <= '0;
      last_v <= 1'b0;
      last_addr <= '0;
      err <= 1'b0;
    end else begin
      done_q <= done;
      st <= fall ? RECV : close ? (bad ? IDLE : DONE) : ((st == DONE) && load_clear) ? IDLE : st;
      cnt <= newb ? ((cnt_e == 6'd63) ? cnt_e : cnt_e + 6'd1) : cnt_e;
      last_v <= newb | (last_v & ~fall);
      if (newb) last_addr <= addr;
      err <= (err & ~fall) | (wr & oor) | (close & bad);
    end
  end
  assign is_done = st == DONE;
endmodule

module cnn_load_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int PARA_X = 3,
  parameter int PARA_Y = 3,
  parameter int PARA_KERNEL = 4,
  parameter int KERNEL_SIZE_MAX = 3,
  parameter int FM_ADDR_WIDTH = 6,
  parameter int WT_ADDR_WIDTH = 6,
  parameter int FM_DEPTH = 32,
  parameter int WT_DEPTH = 64,
  parameter int EXP_FM_BEATS = 18,
  parameter int EXP_WT_BEATS = 4
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]                         fm_data,
  input  logic [FM_ADDR_WIDTH-1:0]                                    fm_addr,
  input  logic                                                        fm_done,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] wt_data,
  input  logic [WT_ADDR_WIDTH*PARA_KERNEL-1:0]                        wt_addr,
  input  logic                                                        wt_done,
  input  logic                                                        load_clear,
  input  logic [FM_ADDR_WIDTH-1:0]                                    fm_rd_addr,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]                         fm_rd_data,
  input  logic [WT_ADDR_WIDTH*PARA_KERNEL-1:0]                        wt_rd_addr,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] wt_rd_data,
  output logic                                                        load_ready,
  output logic                                                        conv_start,
  output logic                                                        fm_err,
  output logic                                                        wt_err
);
  localparam int FW = PARA_X * PARA_Y * DATA_WIDTH;
  localparam int LW = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
  localparam int FAW = $clog2(FM_DEPTH);
  localparam int WAW = $clog2(WT_DEPTH);
  localparam logic [FM_ADDR_WIDTH:0] FM_LIM = (FM_ADDR_WIDTH + 1)'(FM_DEPTH);
  localparam logic [WT_ADDR_WIDTH:0] WT_LIM = (WT_ADDR_WIDTH + 1)'(WT_DEPTH);
  logic fm_wr, fm_ok, fm_rd_ok, fm_is_done, wt_wr, wt_is_done, ready_q;
  logic [PARA_KERNEL-1:0] wt_ok;
  logic [FW-1:0] fm_mem [FM_DEPTH];
  assign fm_ok = {1'b0, fm_addr} < FM_LIM;
  assign fm_rd_ok = {1'b0, fm_rd_addr} < FM_LIM;
  cnn_load_chan #(.AW(FM_ADDR_WIDTH), .EXP(EXP_FM_BEATS)) u_fm (
    .clk(clk), .rst(rst), .done(fm_done), .load_clear(load_clear), .oor(~fm_ok),
    .addr(fm_addr), .wr(fm_wr), .is_done(fm_is_done), .err(fm_err)
  );
  // weight beats are tracked on lane 0's address only
  cnn_load_chan #(.AW(WT_ADDR_WIDTH), .EXP(EXP_WT_BEATS)) u_wt (
    .clk(clk), .rst(rst), .done(wt_done), .load_clear(load_clear), .oor(~&wt_ok),
    .addr(wt_addr[WT_ADDR_WIDTH-1:0]), .wr(wt_wr), .is_done(wt_is_done), .err(wt_err)
  );
  always_ff @(posedge clk) if (fm_wr && fm_ok) fm_mem[fm_addr[FAW-1:0]] <= fm_data;
  always_ff @(posedge clk) begin
    if (rst) fm_rd_data <= '0;
    else fm_rd_data <= fm_rd_ok ? fm_mem[fm_rd_addr[FAW-1:0]] : '0;
  end
  for (genvar k = 0; k < PARA_KERNEL; k++) begin : g_lane
    logic [WT_ADDR_WIDTH-1:0] wa, ra;
    logic [LW-1:0] mem [WT_DEPTH];
    logic [LW-1:0] rq;
    assign wa = wt_addr[k*WT_ADDR_WIDTH +: WT_ADDR_WIDTH];
    assign ra = wt_rd_addr[k*WT_ADDR_WIDTH +: WT_ADDR_WIDTH];
    assign wt_ok[k] = {1'b0, wa} < WT_LIM;
    always_ff @(posedge clk) if (wt_wr && wt_ok[k]) mem[wa[WAW-1:0]] <= wt_data[k*LW +: LW];
    always_ff @(posedge clk) begin
      if (rst) rq <= '0;
      else rq <= ({1'b0, ra} < WT_LIM) ? mem[ra[WAW-1:0]] : '0;
    end
    assign wt_rd_data[k*LW +: LW] = rq;
  end
  assign load_ready = fm_is_done & wt_is_done;
  assign conv_start = load_ready & ~ready_q;
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else ready_q <= load_ready;
  end
endmodule
